// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - shared sample widths and sample-format helpers for the SDR receive chain
package sdr_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int OTR_CNT_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Offset binary to two's complement is a flip of the MSB.
  function automatic sample_t offset_to_signed(input logic [SAMPLE_W-1:0] v);
    return {~v[SAMPLE_W-1], v[SAMPLE_W-2:0]};
  endfunction

  // Clamp a 13-bit signed value into the 12-bit sample range.
  function automatic sample_t sat12(input logic signed [SAMPLE_W:0] v);
    if (v[SAMPLE_W] != v[SAMPLE_W-1])
      return v[SAMPLE_W] ? sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}})
                         : sample_t'({1'b0, {(SAMPLE_W-1){1'b1}}});
    return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/adc_dc_block_if.sv
// rtl/adc_dc_block_if.sv - ADC sample in, conditioned sample and window statistics out
interface adc_dc_block_if;
  import sdr_pkg::*;

  logic [SAMPLE_W-1:0]  adc_data;
  logic                 adc_otr;
  logic                 bypass;
  logic                 dc_freeze;
  sample_t              out_data;
  logic                 out_vld;
  sample_t              dc_est;
  logic [SAMPLE_W-2:0]  peak_val;
  logic [OTR_CNT_W-1:0] otr_cnt;
  logic                 stat_vld;

  modport master (
    output adc_data, adc_otr, bypass, dc_freeze,
    input  out_data, out_vld, dc_est, peak_val, otr_cnt, stat_vld
  );

  modport slave (
    input  adc_data, adc_otr, bypass, dc_freeze,
    output out_data, out_vld, dc_est, peak_val, otr_cnt, stat_vld
  );

endinterface

// File: rtl/adc_win_stats.sv
// rtl/adc_win_stats.sv - windowed peak magnitude and out-of-range count over 2^PEAK_LOG2 samples
module adc_win_stats
  import sdr_pkg::*;
#(
  parameter int PEAK_LOG2 = 12
) (
  input  logic                 adc_clk,
  input  logic                 rst_n,
  input  logic                 vld_i,
  input  sample_t              sample_i,
  input  logic                 otr_i,
  output logic [SAMPLE_W-2:0]  peak_val_o,
  output logic [OTR_CNT_W-1:0] otr_cnt_o,
  output logic                 stat_vld_o
);

  logic [PEAK_LOG2-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-2:0]  peak_run_q, peak_run_d, peak_val_q, peak_val_d;
  logic [OTR_CNT_W-1:0] otr_run_q, otr_run_d, otr_cnt_q, otr_cnt_d;
  logic                 stat_vld_q, stat_vld_d;
  logic [SAMPLE_W-2:0]  mag, peak_max;
  logic [OTR_CNT_W-1:0] otr_sum;

  always_comb begin
    // -2048 has no positive twin in 12 bits; report it as full scale.
    if (sample_i == sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}}))
      mag = '1;
    else if (sample_i[SAMPLE_W-1])
      mag = (SAMPLE_W-1)'(-sample_i);
    else
      mag = sample_i[SAMPLE_W-2:0];

    peak_max = (mag > peak_run_q) ? mag : peak_run_q;
    otr_sum  = (otr_i && (otr_run_q != '1)) ? otr_run_q + 1'b1 : otr_run_q;

    cnt_d      = cnt_q;
    peak_run_d = peak_run_q;
    otr_run_d  = otr_run_q;
    peak_val_d = peak_val_q;
    otr_cnt_d  = otr_cnt_q;
    stat_vld_d = 1'b0;

    if (vld_i) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        peak_val_d = peak_max;
        otr_cnt_d  = otr_sum;
        peak_run_d = '0;
        otr_run_d  = '0;
        stat_vld_d = 1'b1;
      end else begin
        peak_run_d = peak_max;
        otr_run_d  = otr_sum;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      peak_run_q <= '0;
      otr_run_q  <= '0;
      peak_val_q <= '0;
      otr_cnt_q  <= '0;
      stat_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      peak_run_q <= peak_run_d;
      otr_run_q  <= otr_run_d;
      peak_val_q <= peak_val_d;
      otr_cnt_q  <= otr_cnt_d;
      stat_vld_q <= stat_vld_d;
    end
  end

  assign peak_val_o = peak_val_q;
  assign otr_cnt_o  = otr_cnt_q;
  assign stat_vld_o = stat_vld_q;

endmodule

// File: rtl/adc_dc_block.sv
// rtl/adc_dc_block.sv - AD9226 offset-binary to signed conversion with leaky-integrator DC removal
module adc_dc_block
  import sdr_pkg::*;
#(
  parameter int DC_SHIFT  = 10,
  parameter int PEAK_LOG2 = 12
) (
  input  logic           adc_clk,
  input  logic           rst_n,
  adc_dc_block_if.slave  bus
);

  localparam int ACC_W = SAMPLE_W + 1 + DC_SHIFT;

  sample_t                x_q;
  logic                   otr_q, vld1_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  sample_t                out_data_q, out_data_d, dc_est_q, dc;
  logic                   otr2_q, out_vld_q;
  logic signed [SAMPLE_W:0] e;

  always_comb begin
    dc = sample_t'(acc_q >>> DC_SHIFT);
    e  = {x_q[SAMPLE_W-1], x_q} - {dc[SAMPLE_W-1], dc};

    // The integrator sees the unclamped error so it tracks full-scale steps.
    acc_d = acc_q;
    if (!bus.bypass && !bus.dc_freeze)
      acc_d = acc_q + {{(ACC_W-SAMPLE_W-1){e[SAMPLE_W]}}, e};

    out_data_d = bus.bypass ? x_q : sat12(e);
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      otr_q      <= 1'b0;
      vld1_q     <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
      dc_est_q   <= '0;
      otr2_q     <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      x_q        <= offset_to_signed(bus.adc_data);
      otr_q      <= bus.adc_otr;
      vld1_q     <= 1'b1;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      dc_est_q   <= dc;
      otr2_q     <= otr_q;
      out_vld_q  <= vld1_q;
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.dc_est   = dc_est_q;

  adc_win_stats #(
    .PEAK_LOG2 (PEAK_LOG2)
  ) u_stats (
    .adc_clk    (adc_clk),
    .rst_n      (rst_n),
    .vld_i      (out_vld_q),
    .sample_i   (out_data_q),
    .otr_i      (otr2_q),
    .peak_val_o (bus.peak_val),
    .otr_cnt_o  (bus.otr_cnt),
    .stat_vld_o (bus.stat_vld)
  );

endmodule

// File: doc/adc_dc_block.md
# adc_dc_block

Conditioning stage directly downstream of the AD9226 capture register. It converts the 12-bit offset-binary ADC word to two's complement and removes DC offset with a first-order leaky integrator. It also reports windowed peak magnitude and an out-of-range count for AGC/monitoring. Output feeds the NCO mixer / decimation chain, one sample per adc_clk.

## Interface
- DC_SHIFT, 10: integrator leak shift K; DC corner ≈ fs/(2π·2^K); legal 2..16
- PEAK_LOG2, 12: statistics window = 2^PEAK_LOG2 output samples; legal 2..20
- adc_clk  in  1  sample clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- adc_data  in  12  registered ADC word, offset binary (0x800 = midscale)
- adc_otr  in  1  ADC out-of-range flag, aligned with adc_data
- bypass  in  1  1: skip DC removal, out_data = converted input
- dc_freeze  in  1  1: hold integrator (current DC estimate still subtracted)
- out_data  out  12  signed two's-complement conditioned sample
- out_vld  out  1  out_data valid
- dc_est  out  12  current DC estimate (signed)
- peak_val  out  11  max |out_data| over last completed window
- otr_cnt  out  16  adc_otr count over last completed window, saturating
- stat_vld  out  1  one-cycle pulse when peak_val/otr_cnt update

## Operation
- Conversion: x = {~adc_data[11], adc_data[10:0]} (signed 12).
- Integrator acc: signed, 13+DC_SHIFT bits, reset 0. dc = acc >>> DC_SHIFT, truncated to 12 bits (arithmetic shift, floor).
- e = x − dc, 13-bit signed, full precision.
- Unless bypass or dc_freeze: acc ← acc + sign-extended e. bypass holds acc.
- out_data = bypass ? x : sat12(e); sat12 clamps to [−2048, +2047].
- dc_est = dc, registered with out_data.
- Stats, counted only on out_vld cycles: window counter PEAK_LOG2 bits. mag = |out_data|, with −2048 mapped to 2047 (fits 11 bits). peak_run = max(peak_run, mag). otr_run increments when the delayed otr is 1 and saturates at 0xFFFF.
- On the last sample of a window (counter all ones): peak_val ← max(peak_run, mag of that sample); otr_cnt ← otr_run + that sample's otr (saturating); stat_vld = 1. Running values restart from 0 the next cycle, so no sample is lost or double-counted.
- Changing bypass or dc_freeze mid-stream takes effect on the next stage-2 edge with no glitch. The accumulator is not cleared.

## Timing
- Stage 1 (edge n): x_r ← conversion of adc_data, otr_r ← adc_otr.
- Stage 2 (edge n+1): out_data, dc_est, acc update. Latency from adc_data to out_data is 2 edges.
- out_vld: 0 in reset, 1 from the second edge after rst_n deasserts, then continuously 1.
- stat_vld: first pulse 2^PEAK_LOG2 cycles after out_vld first rises. Repeats every 2^PEAK_LOG2 cycles.
- Reset values: out_data 0, out_vld 0, dc_est 0, peak_val 0, otr_cnt 0, stat_vld 0. Internal state (acc, window counter, running stats, pipeline) is 0.
- Reset asserted mid-operation clears everything immediately (async). There is no partial-window report.

## Structure
- Shared package `sdr_pkg`: SAMPLE_W = 12, offset-to-signed conversion function, sat12 function, OTR_CNT_W = 16.
- Sub-module `adc_win_stats` contains the window counter, peak_run/otr_run, and the report registers. The parent holds conversion, integrator and output registers.

## Test plan
- Bypass = 1: adc_data 0x000/0x800/0xFFF → out_data −2048/0/+2047, 2 edges later; out_vld rises on the 2nd edge after reset release.
- DC_SHIFT = 4, constant adc_data 0x900 (x = +256): dc_est ramps monotonically to 256. out_data starts at +256 and decays to 0 within 200 samples, then stays 0.
- Saturation: DC_SHIFT = 4, settle at adc_data 0x000 (dc = −2048), step to 0xFFF → e = 4095, out_data = +2047 (clamped). The acc update uses the unsaturated e.
- dc_freeze = 1 after settling at +256, then input 0x800 → out_data = −256 held constant, dc_est frozen at 256.
- PEAK_LOG2 = 2, bypass, samples +5, −300, +7, −2048 with otr 0,1,1,0 → stat_vld pulse, peak_val 2047, otr_cnt 2. Next window of all 0x800 with otr 0 → peak_val 0, otr_cnt 0.
- Assert rst_n low mid-window, release → all outputs 0, and the first stat_vld arrives a full window after the new out_vld.
